mem_port_arbiter: RTL and testbench
===================================

// Module: mem_port_arbiter
// PURPOSE
//   Shares one single-ported memory bus between the fetch-stage instruction port and the
//   mem-stage data port. Serializes requests; data port has fixed priority. Only one
//   transfer is outstanding at a time. Drives per-port stall signals into the hazard unit
//   so the pipeline freezes until its transfer completes.
// PARAMETERS
//   AW              32   address width (byte address; m_addr forwarded unmodified)
//   DW              32   data width
//   TIMEOUT_CYCLES  255  max WAIT cycles before bus error (only with MEM_ARB_TIMEOUT_EN)
// PORTS
//   clk       in   1      clock; all state updates on posedge
//   rst       in   1      synchronous, active-high reset
//   i_req     in   1      instruction read request; held while i_stall=1
//   i_addr    in   AW     instruction address (pc_F)
//   i_rdata   out  DW     instruction word; valid in the cycle i_stall drops
//   i_stall   out  1      instruction port not yet served
//   d_req     in   1      data request; held while d_stall=1
//   d_we      in   1      1=write, 0=read
//   d_wstrb   in   DW/8   byte enables for writes
//   d_addr    in   AW     data address (alu_out_M)
//   d_wdata   in   DW     write data (write_data_M)
//   d_rdata   out  DW     read data; valid in the cycle d_stall drops
//   d_stall   out  1      data port not yet served
//   m_req     out  1      bus request; held until m_gnt
//   m_we      out  1      bus write enable
//   m_wstrb   out  DW/8   bus byte enables (all ones for instruction reads)
//   m_addr    out  AW     bus address
//   m_wdata   out  DW     bus write data
//   m_gnt     in   1      bus accepted request (sampled only while m_req=1)
//   m_rvalid  in   1      read data valid / write ack (sampled only in WAIT)
//   m_rdata   in   DW     bus read data
//   bus_err   out  1      one-cycle pulse on timeout abort (tied 0 without macro)
// BEHAVIOUR
//   FSM states: IDLE, ISSUE, WAIT. Owner register: OWN_I / OWN_D.
//   IDLE: if d_req -> latch d_* into bus regs, owner=OWN_D, go ISSUE; else if i_req -> latch
//     i_addr, we=0, wstrb=all ones, owner=OWN_I, go ISSUE; else stay IDLE.
//   ISSUE: m_req=1 from latched regs (stable); on m_gnt -> WAIT.
//   WAIT: m_req=0; on m_rvalid -> capture m_rdata, go IDLE.
//   Completion cycle = WAIT with m_rvalid=1: owner's stall=0, rdata=m_rdata combinationally.
//   i_stall = i_req & ~(WAIT & m_rvalid & owner==OWN_I); d_stall analogous for OWN_D.
//   Min latency: req seen in cycle 0, m_req in cycle 1 (gnt same cycle), rvalid earliest
//     cycle 2 -> 3 cycles from request to stall release.
//   Both ports request in IDLE: D served first; I stays stalled, served next.
//   Back-to-back: completion returns to IDLE; new request is arbitrated the following cycle.
//   Request held after completion (pipeline frozen elsewhere) is re-issued; reads and
//     same-data writes are idempotent, so this is legal.
//   Request dropped while in ISSUE/WAIT (flush): transfer still finishes on bus; result
//     discarded; no stall asserted since req=0.
//   Reset (any state): state=IDLE, owner=OWN_I, m_req=0, m_we=0, m_wstrb=0, m_addr=0,
//     m_wdata=0, bus_err=0, timeout count=0; in-flight m_rvalid after reset is ignored.
//   i_rdata/d_rdata outside completion cycle: last captured value (0 after reset).
// CONFIGURATION
//   MEM_ARB_TIMEOUT_EN defined: counter clears on entering WAIT, increments each WAIT cycle
//     without m_rvalid; when count reaches TIMEOUT_CYCLES, completes transfer with rdata=0,
//     drops owner's stall, pulses bus_err for 1 cycle, returns IDLE.
//   Undefined: no counter; WAIT lasts until m_rvalid; bus_err constant 0.
// STRUCTURE
//   Shared header mem_arb_defs.vh: state encodings (ST_IDLE/ST_ISSUE/ST_WAIT), owner codes,
//     default TIMEOUT_CYCLES.
//   One sub-module: arb_timeout_cnt (clear/enable/expire), instantiated only under macro.
// TESTING
//   i_req=1,i_addr=0x00400000; m_gnt same cycle, m_rvalid 1 cycle later, m_rdata=0x24020005
//     -> i_stall released cycle 2, i_rdata=0x24020005, m_wstrb=4'hF, m_we=0.
//   i_req and d_req (read 0x10010004) same cycle -> m_addr=0x10010004 first; i_stall stays 1
//     until second transfer completes.
//   d write 0x10010008, wstrb=4'b0011, wdata=0xDEADBEEF; m_gnt delayed 3 cycles -> m_req and
//     bus regs stable all 3 cycles; d_stall drops on ack.
//   rst asserted in WAIT -> next cycle IDLE, m_req=0; late m_rvalid ignored, no stall release.
//   MEM_ARB_TIMEOUT_EN, TIMEOUT_CYCLES=4, no m_rvalid -> bus_err pulses once after 4 WAIT
//     cycles, d_rdata=0, d_stall drops.

Source files
------------

// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and defaults for the instruction/data memory port arbiter.
package mem_port_arbiter_pkg;

   // Transfer sequencer states
   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_WAIT  = 2'd2
   } arb_state_e;

   // Which pipeline port owns the transfer in flight
   typedef enum logic {
      OWN_I = 1'b0,
      OWN_D = 1'b1
   } arb_owner_e;

   localparam int unsigned DEF_AW             = 32;
   localparam int unsigned DEF_DW             = 32;
   localparam int unsigned DEF_TIMEOUT_CYCLES = 255;

   // Bits needed to hold a count of 0..max_val
   function automatic int unsigned cnt_width(input int unsigned max_val);
      return (max_val < 1) ? 1 : $clog2(max_val + 1);
   endfunction

endpackage

// File: rtl/mem_port_arbiter_timeout.sv
// WAIT-phase watchdog counter; only built when MEM_ARB_TIMEOUT_EN is defined.
// Clears on clr, counts while en, saturates at MAX_CNT and flags expire_c there.
`ifdef MEM_ARB_TIMEOUT_EN
module arb_timeout_cnt
   import mem_port_arbiter_pkg::*;
#(
   parameter int unsigned MAX_CNT = DEF_TIMEOUT_CYCLES
) (
   input  logic clk,
   input  logic rst,
   input  logic clr,
   input  logic en,
   output logic expire_c
);

   localparam int unsigned CW = cnt_width(MAX_CNT);

   logic [CW-1:0] cnt_q;
   logic [CW-1:0] cnt_d;

   // Next count: clear wins, then saturating increment
   always_comb begin
      cnt_d = cnt_q;
      if (clr) begin
         cnt_d = '0;
      end else if (en && (cnt_q != CW'(MAX_CNT))) begin
         cnt_d = cnt_q + CW'(1);
      end
   end

   // Count register
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign expire_c = (cnt_q == CW'(MAX_CNT));

endmodule
`endif

// File: rtl/mem_port_arbiter.sv
// Serializes fetch-stage and mem-stage accesses onto one memory bus.
// Data port has fixed priority; one transfer outstanding at a time.
// Optional WAIT timeout with bus_err pulse: define MEM_ARB_TIMEOUT_EN.
module mem_port_arbiter
   import mem_port_arbiter_pkg::*;
#(
   parameter int unsigned AW             = DEF_AW,
   parameter int unsigned DW             = DEF_DW,
   parameter int unsigned TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            i_req,
   input  logic [AW-1:0]   i_addr,
   output logic [DW-1:0]   i_rdata,
   output logic            i_stall,
   input  logic            d_req,
   input  logic            d_we,
   input  logic [DW/8-1:0] d_wstrb,
   input  logic [AW-1:0]   d_addr,
   input  logic [DW-1:0]   d_wdata,
   output logic [DW-1:0]   d_rdata,
   output logic            d_stall,
   output logic            m_req,
   output logic            m_we,
   output logic [DW/8-1:0] m_wstrb,
   output logic [AW-1:0]   m_addr,
   output logic [DW-1:0]   m_wdata,
   input  logic            m_gnt,
   input  logic            m_rvalid,
   input  logic [DW-1:0]   m_rdata,
   output logic            bus_err
);

   localparam int unsigned SW = DW / 8;

   arb_state_e    state_q,   state_d;
   arb_owner_e    owner_q,   owner_d;
   logic          m_req_q,   m_req_d;
   logic          m_we_q,    m_we_d;
   logic [SW-1:0] m_wstrb_q, m_wstrb_d;
   logic [AW-1:0] m_addr_q,  m_addr_d;
   logic [DW-1:0] m_wdata_q, m_wdata_d;
   logic [DW-1:0] i_rdata_q, i_rdata_d;
   logic [DW-1:0] d_rdata_q, d_rdata_d;
   logic          bus_err_q, bus_err_d;

   logic          expire_c;
   logic          rsp_c;
   logic          abort_c;
   logic          done_i_c;
   logic          done_d_c;
   logic [DW-1:0] rsp_data_c;

`ifdef MEM_ARB_TIMEOUT_EN
   logic to_clr_c;
   logic to_en_c;

   // Restart the watchdog on grant, count WAIT cycles with no response
   assign to_clr_c = (state_q == ST_ISSUE) && m_gnt;
   assign to_en_c  = (state_q == ST_WAIT) && !m_rvalid;

   arb_timeout_cnt #(
      .MAX_CNT (TIMEOUT_CYCLES)
   ) u_timeout (
      .clk      (clk),
      .rst      (rst),
      .clr      (to_clr_c),
      .en       (to_en_c),
      .expire_c (expire_c)
   );
`else
   logic unused_timeout;

   assign unused_timeout = |TIMEOUT_CYCLES;
   assign expire_c       = 1'b0;
`endif

   // Completion qualifiers: a real response beats a simultaneous timeout
   assign rsp_c      = (state_q == ST_WAIT) && (m_rvalid || expire_c);
   assign abort_c    = (state_q == ST_WAIT) && !m_rvalid && expire_c;
   assign rsp_data_c = m_rvalid ? m_rdata : '0;
   assign done_i_c   = rsp_c && (owner_q == OWN_I);
   assign done_d_c   = rsp_c && (owner_q == OWN_D);

   // Stall release and read data are combinational in the completion cycle
   assign i_stall = i_req && !done_i_c;
   assign d_stall = d_req && !done_d_c;
   assign i_rdata = (done_i_c && i_req) ? rsp_data_c : i_rdata_q;
   assign d_rdata = (done_d_c && d_req) ? rsp_data_c : d_rdata_q;

   assign m_req   = m_req_q;
   assign m_we    = m_we_q;
   assign m_wstrb = m_wstrb_q;
   assign m_addr  = m_addr_q;
   assign m_wdata = m_wdata_q;
   assign bus_err = bus_err_q;

   // Arbitration, bus request sequencing and response capture
   always_comb begin
      state_d   = state_q;
      owner_d   = owner_q;
      m_req_d   = m_req_q;
      m_we_d    = m_we_q;
      m_wstrb_d = m_wstrb_q;
      m_addr_d  = m_addr_q;
      m_wdata_d = m_wdata_q;
      i_rdata_d = i_rdata_q;
      d_rdata_d = d_rdata_q;
      bus_err_d = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (d_req) begin
               owner_d   = OWN_D;
               m_we_d    = d_we;
               m_wstrb_d = d_wstrb;
               m_addr_d  = d_addr;
               m_wdata_d = d_wdata;
               m_req_d   = 1'b1;
               state_d   = ST_ISSUE;
            end else if (i_req) begin
               owner_d   = OWN_I;
               m_we_d    = 1'b0;
               m_wstrb_d = '1;
               m_addr_d  = i_addr;
               m_req_d   = 1'b1;
               state_d   = ST_ISSUE;
            end
         end

         ST_ISSUE: begin
            if (m_gnt) begin
               m_req_d = 1'b0;
               state_d = ST_WAIT;
            end
         end

         ST_WAIT: begin
            if (rsp_c) begin
               state_d   = ST_IDLE;
               bus_err_d = abort_c;
               // A flushed requester's result is dropped
               if (done_i_c && i_req) begin
                  i_rdata_d = rsp_data_c;
               end
               if (done_d_c && d_req) begin
                  d_rdata_d = rsp_data_c;
               end
            end
         end

         default: begin
            state_d = ST_IDLE;
            m_req_d = 1'b0;
         end
      endcase
   end

   // State, owner, bus and capture registers
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= ST_IDLE;
         owner_q   <= OWN_I;
         m_req_q   <= 1'b0;
         m_we_q    <= 1'b0;
         m_wstrb_q <= '0;
         m_addr_q  <= '0;
         m_wdata_q <= '0;
         i_rdata_q <= '0;
         d_rdata_q <= '0;
         bus_err_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         owner_q   <= owner_d;
         m_req_q   <= m_req_d;
         m_we_q    <= m_we_d;
         m_wstrb_q <= m_wstrb_d;
         m_addr_q  <= m_addr_d;
         m_wdata_q <= m_wdata_d;
         i_rdata_q <= i_rdata_d;
         d_rdata_q <= d_rdata_d;
         bus_err_q <= bus_err_d;
      end
   end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed scenarios plus a
// randomized run against a bus-protocol / memory reference model.
module tb_mem_port_arbiter;

   logic        clk = 1'b0;
   logic        rst;
   logic        i_req;
   logic [31:0] i_addr;
   logic [31:0] i_rdata;
   logic        i_stall;
   logic        d_req;
   logic        d_we;
   logic [3:0]  d_wstrb;
   logic [31:0] d_addr;
   logic [31:0] d_wdata;
   logic [31:0] d_rdata;
   logic        d_stall;
   logic        m_req;
   logic        m_we;
   logic [3:0]  m_wstrb;
   logic [31:0] m_addr;
   logic [31:0] m_wdata;
   logic        m_gnt;
   logic        m_rvalid;
   logic [31:0] m_rdata;
   logic        bus_err;

   int tests = 0;
   int fails = 0;

   bit [31:0] mem_m [bit [31:0]];

   always #5 clk = ~clk;

   mem_port_arbiter #(
      .AW (32), .DW (32), .TIMEOUT_CYCLES (4)
   ) dut (
      .clk (clk), .rst (rst),
      .i_req (i_req), .i_addr (i_addr), .i_rdata (i_rdata), .i_stall (i_stall),
      .d_req (d_req), .d_we (d_we), .d_wstrb (d_wstrb), .d_addr (d_addr),
      .d_wdata (d_wdata), .d_rdata (d_rdata), .d_stall (d_stall),
      .m_req (m_req), .m_we (m_we), .m_wstrb (m_wstrb), .m_addr (m_addr),
      .m_wdata (m_wdata), .m_gnt (m_gnt), .m_rvalid (m_rvalid), .m_rdata (m_rdata),
      .bus_err (bus_err)
   );

   // Memory contents seen by the bus slave model
   function automatic bit [31:0] mem_rd(input bit [31:0] a);
      if (mem_m.exists(a)) return mem_m[a];
      return {a[15:0] ^ 16'hC3A5, a[15:0]};
   endfunction

   // Drive phase: just after the rising edge
   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   // Sample phase: falling edge, inputs settled
   task automatic sample();
      @(negedge clk);
   endtask

   task automatic idle_inputs();
      rst = 1'b0; i_req = 1'b0; i_addr = 32'h0;
      d_req = 1'b0; d_we = 1'b0; d_wstrb = 4'h0; d_addr = 32'h0; d_wdata = 32'h0;
      m_gnt = 1'b0; m_rvalid = 1'b0; m_rdata = 32'h0;
   endtask

   task automatic test_reset();
      idle_inputs();
      rst = 1'b1; i_req = 1'b1; d_req = 1'b1; d_we = 1'b1; d_wstrb = 4'hA;
      d_addr = 32'h1234_5678; d_wdata = 32'h9ABC_DEF0; m_gnt = 1'b1; m_rvalid = 1'b1;
      m_rdata = 32'hFEED_FACE;
      next_cycle(); next_cycle(); sample();
      tests++; if (m_req !== 1'b0) begin fails++; $display("FAIL rst_m_req got=%0h exp=0", m_req); end
      tests++; if (m_we !== 1'b0) begin fails++; $display("FAIL rst_m_we got=%0h exp=0", m_we); end
      tests++; if (m_wstrb !== 4'h0) begin fails++; $display("FAIL rst_m_wstrb got=%0h exp=0", m_wstrb); end
      tests++; if (m_addr !== 32'h0) begin fails++; $display("FAIL rst_m_addr got=%0h exp=0", m_addr); end
      tests++; if (m_wdata !== 32'h0) begin fails++; $display("FAIL rst_m_wdata got=%0h exp=0", m_wdata); end
      tests++; if (bus_err !== 1'b0) begin fails++; $display("FAIL rst_bus_err got=%0h exp=0", bus_err); end
      tests++; if (i_rdata !== 32'h0) begin fails++; $display("FAIL rst_i_rdata got=%0h exp=0", i_rdata); end
      tests++; if (d_rdata !== 32'h0) begin fails++; $display("FAIL rst_d_rdata got=%0h exp=0", d_rdata); end
      next_cycle();
      idle_inputs();
      sample();
      tests++; if ({m_req, i_stall, d_stall} !== 3'b000) begin fails++; $display("FAIL rst_quiet got=%0b exp=000", {m_req, i_stall, d_stall}); end
      next_cycle();
   endtask

   task automatic test_min_latency();
      i_req = 1'b1; i_addr = 32'h0040_0000;
      sample();
      tests++; if ({i_stall, m_req} !== 2'b10) begin fails++; $display("FAIL lat_c0 got=%0b exp=10", {i_stall, m_req}); end
      next_cycle();
      m_gnt = 1'b1;
      sample();
      tests++; if (m_req !== 1'b1) begin fails++; $display("FAIL lat_c1_m_req got=%0h exp=1", m_req); end
      tests++; if (m_addr !== 32'h0040_0000) begin fails++; $display("FAIL lat_c1_m_addr got=%0h exp=00400000", m_addr); end
      tests++; if ({m_we, m_wstrb} !== 5'b0_1111) begin fails++; $display("FAIL lat_c1_we_wstrb got=%0h exp=0f", {m_we, m_wstrb}); end
      tests++; if (i_stall !== 1'b1) begin fails++; $display("FAIL lat_c1_i_stall got=%0h exp=1", i_stall); end
      next_cycle();
      m_gnt = 1'b0; m_rvalid = 1'b1; m_rdata = 32'h2402_0005;
      sample();
      tests++; if (i_stall !== 1'b0) begin fails++; $display("FAIL lat_c2_i_stall got=%0h exp=0", i_stall); end
      tests++; if (i_rdata !== 32'h2402_0005) begin fails++; $display("FAIL lat_c2_i_rdata got=%0h exp=24020005", i_rdata); end
      tests++; if (m_req !== 1'b0) begin fails++; $display("FAIL lat_c2_m_req got=%0h exp=0", m_req); end
      next_cycle();
      i_req = 1'b0; m_rvalid = 1'b0; m_rdata = 32'h0;
      sample();
      tests++; if (i_rdata !== 32'h2402_0005) begin fails++; $display("FAIL lat_hold_i_rdata got=%0h exp=24020005", i_rdata); end
      tests++; if (m_req !== 1'b0) begin fails++; $display("FAIL lat_c3_m_req got=%0h exp=0", m_req); end
      next_cycle();
   endtask

   task automatic test_priority();
      i_req = 1'b1; i_addr = 32'h0040_0004;
      d_req = 1'b1; d_we = 1'b0; d_wstrb = 4'hF; d_addr = 32'h1001_0004;
      next_cycle();
      m_gnt = 1'b1;
      sample();
      tests++; if (m_addr !== 32'h1001_0004) begin fails++; $display("FAIL pri_first_addr got=%0h exp=10010004", m_addr); end
      tests++; if ({m_req, m_we} !== 2'b10) begin fails++; $display("FAIL pri_first_req_we got=%0b exp=10", {m_req, m_we}); end
      next_cycle();
      m_gnt = 1'b0; m_rvalid = 1'b1; m_rdata = 32'h1111_2222;
      sample();
      tests++; if ({d_stall, i_stall} !== 2'b01) begin fails++; $display("FAIL pri_d_done_stalls got=%0b exp=01", {d_stall, i_stall}); end
      tests++; if (d_rdata !== 32'h1111_2222) begin fails++; $display("FAIL pri_d_rdata got=%0h exp=11112222", d_rdata); end
      next_cycle();
      d_req = 1'b0; m_rvalid = 1'b0;
      sample();
      tests++; if ({m_req, i_stall} !== 2'b01) begin fails++; $display("FAIL pri_gap got=%0b exp=01", {m_req, i_stall}); end
      next_cycle();
      m_gnt = 1'b1;
      sample();
      tests++; if ({m_req, m_addr} !== {1'b1, 32'h0040_0004}) begin fails++; $display("FAIL pri_second_issue got=%0h exp=100400004", {m_req, m_addr}); end
      tests++; if (i_stall !== 1'b1) begin fails++; $display("FAIL pri_second_i_stall got=%0h exp=1", i_stall); end
      next_cycle();
      m_gnt = 1'b0; m_rvalid = 1'b1; m_rdata = 32'h3333_4444;
      sample();
      tests++; if ({i_stall, i_rdata} !== {1'b0, 32'h3333_4444}) begin fails++; $display("FAIL pri_i_done got=%0h exp=033334444", {i_stall, i_rdata}); end
      next_cycle();
      idle_inputs();
      next_cycle();
   endtask

   task automatic test_gnt_delay_write();
      d_req = 1'b1; d_we = 1'b1; d_wstrb = 4'b0011; d_addr = 32'h1001_0008; d_wdata = 32'hDEAD_BEEF;
      next_cycle();
      for (int k = 0; k < 4; k++) begin
         m_gnt = (k == 3);
         sample();
         tests++;
         if ({m_req, m_we, m_wstrb, m_addr, m_wdata} !== {1'b1, 1'b1, 4'b0011, 32'h1001_0008, 32'hDEAD_BEEF}) begin
            fails++; $display("FAIL wr_stable_%0d got=%0h exp=%0h", k, {m_req, m_we, m_wstrb, m_addr, m_wdata},
                              {1'b1, 1'b1, 4'b0011, 32'h1001_0008, 32'hDEAD_BEEF});
         end
         tests++; if (d_stall !== 1'b1) begin fails++; $display("FAIL wr_stall_%0d got=%0h exp=1", k, d_stall); end
         next_cycle();
      end
      m_gnt = 1'b0; m_rvalid = 1'b1; m_rdata = 32'h55AA_55AA;
      sample();
      tests++; if ({d_stall, m_req} !== 2'b00) begin fails++; $display("FAIL wr_ack got=%0b exp=00", {d_stall, m_req}); end
      next_cycle();
      idle_inputs();
      next_cycle();
   endtask

`ifdef MEM_ARB_TIMEOUT_EN
   task automatic test_timeout();
      d_req = 1'b1; d_we = 1'b0; d_wstrb = 4'hF; d_addr = 32'h1001_0010; m_rdata = 32'hFFFF_FFFF;
      next_cycle();
      m_gnt = 1'b1;
      sample();
      tests++; if (m_req !== 1'b1) begin fails++; $display("FAIL to_issue got=%0h exp=1", m_req); end
      next_cycle();
      m_gnt = 1'b0;
      for (int k = 1; k <= 4; k++) begin
         sample();
         tests++; if ({d_stall, bus_err} !== 2'b10) begin fails++; $display("FAIL to_wait_%0d got=%0b exp=10", k, {d_stall, bus_err}); end
         next_cycle();
      end
      sample();
      tests++; if ({d_stall, d_rdata} !== {1'b0, 32'h0}) begin fails++; $display("FAIL to_abort got=%0h exp=0", {d_stall, d_rdata}); end
      next_cycle();
      d_req = 1'b0;
      sample();
      tests++; if ({bus_err, m_req} !== 2'b10) begin fails++; $display("FAIL to_bus_err got=%0b exp=10", {bus_err, m_req}); end
      tests++; if (d_rdata !== 32'h0) begin fails++; $display("FAIL to_rdata_hold got=%0h exp=0", d_rdata); end
      next_cycle();
      sample();
      tests++; if (bus_err !== 1'b0) begin fails++; $display("FAIL to_pulse_end got=%0h exp=0", bus_err); end
      idle_inputs();
      next_cycle();
   endtask
`else
   task automatic test_no_timeout();
      d_req = 1'b1; d_we = 1'b0; d_wstrb = 4'hF; d_addr = 32'h1001_0010;
      next_cycle();
      m_gnt = 1'b1;
      next_cycle();
      m_gnt = 1'b0;
      for (int k = 0; k < 8; k++) begin
         sample();
         tests++; if ({d_stall, bus_err} !== 2'b10) begin fails++; $display("FAIL nto_wait_%0d got=%0b exp=10", k, {d_stall, bus_err}); end
         next_cycle();
      end
      m_rvalid = 1'b1; m_rdata = 32'h7777_0001;
      sample();
      tests++; if ({d_stall, d_rdata} !== {1'b0, 32'h7777_0001}) begin fails++; $display("FAIL nto_done got=%0h exp=077770001", {d_stall, d_rdata}); end
      next_cycle();
      idle_inputs();
      next_cycle();
   endtask
`endif

   task automatic test_reset_in_wait();
      i_req = 1'b1; i_addr = 32'h0040_0020;
      next_cycle();
      m_gnt = 1'b1;
      next_cycle();
      m_gnt = 1'b0; rst = 1'b1;
      next_cycle();
      rst = 1'b0; m_rvalid = 1'b1; m_rdata = 32'hBAD0_BAD0;
      sample();
      tests++; if ({m_req, i_stall} !== 2'b01) begin fails++; $display("FAIL rw_after_rst got=%0b exp=01", {m_req, i_stall}); end
      tests++; if (i_rdata !== 32'h0) begin fails++; $display("FAIL rw_rdata got=%0h exp=0", i_rdata); end
      next_cycle();
      m_rvalid = 1'b0; m_gnt = 1'b1;
      sample();
      tests++; if ({m_req, m_addr} !== {1'b1, 32'h0040_0020}) begin fails++; $display("FAIL rw_reissue got=%0h exp=100400020", {m_req, m_addr}); end
      next_cycle();
      m_gnt = 1'b0; m_rvalid = 1'b1; m_rdata = 32'h0BAD_F00D;
      sample();
      tests++; if ({i_stall, i_rdata} !== {1'b0, 32'h0BAD_F00D}) begin fails++; $display("FAIL rw_done got=%0h exp=00badf00d", {i_stall, i_rdata}); end
      next_cycle();
      idle_inputs();
      next_cycle();
   endtask

   task automatic test_random(input int ncyc);
      bit        pend = 1'b0, p_own_d = 1'b0, p_we = 1'b0;
      bit [3:0]  p_wstrb = 4'h0;
      bit [31:0] p_addr = 32'h0, p_wdata = 32'h0;
      int        p_age = 0;
      bit        prev_idle = 1'b1, prev_held = 1'b0, prev_ireq = 1'b0, prev_dreq = 1'b0, prev_dwe = 1'b0;
      bit [3:0]  prev_dwstrb = 4'h0;
      bit [31:0] prev_iaddr = 32'h0, prev_daddr = 32'h0, prev_dwdata = 32'h0;
      bit        h_we = 1'b0, h_own_d = 1'b0;
      bit [3:0]  h_wstrb = 4'h0;
      bit [31:0] h_addr = 32'h0, h_wdata = 32'h0;
      bit        i_done = 1'b0, d_done = 1'b0, i_blk = 1'b0, d_blk = 1'b0;
      bit        cmpl, busy, exp_mreq, exp_is, exp_ds;
      bit [31:0] v;
      idle_inputs();
      rst = 1'b1;
      next_cycle();
      rst = 1'b0;
      for (int c = 0; c < ncyc; c++) begin
         busy = m_req || pend;
         // Ports hold requests while stalled; occasional flush, no re-raise until the bus drains
         if (!i_req || i_done) begin
            if (i_blk && busy) i_req = 1'b0;
            else begin
               i_blk = 1'b0; i_req = ($urandom_range(0, 2) != 0);
               i_addr = 32'h0040_0000 + 32'($urandom_range(0, 15)) * 32'd4;
            end
         end else if ($urandom_range(0, 15) == 0) begin
            i_req = 1'b0; i_blk = 1'b1;
         end
         if (!d_req || d_done) begin
            if (d_blk && busy) d_req = 1'b0;
            else begin
               d_blk = 1'b0; d_req = ($urandom_range(0, 2) == 0);
               d_we = ($urandom_range(0, 1) == 1); d_wstrb = 4'($urandom_range(1, 15));
               d_addr = 32'h1001_0000 + 32'($urandom_range(0, 7)) * 32'd4; d_wdata = $urandom;
            end
         end else if ($urandom_range(0, 15) == 0) begin
            d_req = 1'b0; d_blk = 1'b1;
         end
         // Bus slave: random grant, bounded response latency, stray rvalid when idle
         m_gnt = ($urandom_range(0, 1) == 1);
         if (pend) m_rvalid = (p_age >= 2) || ($urandom_range(0, 1) == 1);
         else      m_rvalid = ($urandom_range(0, 3) == 0);
         m_rdata = (pend && !p_we) ? mem_rd(p_addr) : $urandom;
         sample();
         cmpl = pend && m_rvalid;
         exp_mreq = prev_idle ? (prev_ireq || prev_dreq) : prev_held;
         tests++; if (m_req !== exp_mreq) begin fails++; $display("FAIL rnd_m_req c=%0d got=%0h exp=%0h", c, m_req, exp_mreq); end
         if (m_req && prev_idle) begin
            h_own_d = prev_dreq;
            h_we    = prev_dreq ? prev_dwe : 1'b0;
            h_wstrb = prev_dreq ? prev_dwstrb : 4'hF;
            h_addr  = prev_dreq ? prev_daddr : prev_iaddr;
            h_wdata = prev_dwdata;
         end
         if (m_req) begin
            tests++;
            if ({m_we, m_wstrb, m_addr} !== {h_we, h_wstrb, h_addr}) begin
               fails++; $display("FAIL rnd_bus_fields c=%0d got=%0h exp=%0h", c, {m_we, m_wstrb, m_addr}, {h_we, h_wstrb, h_addr});
            end
            if (h_we) begin
               tests++; if (m_wdata !== h_wdata) begin fails++; $display("FAIL rnd_m_wdata c=%0d got=%0h exp=%0h", c, m_wdata, h_wdata); end
            end
         end
         exp_is = i_req && !(cmpl && !p_own_d);
         exp_ds = d_req && !(cmpl && p_own_d);
         tests++; if (i_stall !== exp_is) begin fails++; $display("FAIL rnd_i_stall c=%0d got=%0h exp=%0h", c, i_stall, exp_is); end
         tests++; if (d_stall !== exp_ds) begin fails++; $display("FAIL rnd_d_stall c=%0d got=%0h exp=%0h", c, d_stall, exp_ds); end
         if (cmpl && !p_own_d && i_req) begin
            tests++; if (i_rdata !== mem_rd(p_addr)) begin fails++; $display("FAIL rnd_i_rdata c=%0d got=%0h exp=%0h", c, i_rdata, mem_rd(p_addr)); end
         end
         if (cmpl && p_own_d && d_req && !p_we) begin
            tests++; if (d_rdata !== mem_rd(p_addr)) begin fails++; $display("FAIL rnd_d_rdata c=%0d got=%0h exp=%0h", c, d_rdata, mem_rd(p_addr)); end
         end
         tests++; if (bus_err !== 1'b0) begin fails++; $display("FAIL rnd_bus_err c=%0d got=%0h exp=0", c, bus_err); end
         // Model bookkeeping for the next cycle
         i_done = cmpl && !p_own_d && i_req;
         d_done = cmpl && p_own_d && d_req;
         if (cmpl && p_we) begin
            v = mem_rd(p_addr);
            for (int b = 0; b < 4; b++) if (p_wstrb[b]) v[8*b +: 8] = p_wdata[8*b +: 8];
            mem_m[p_addr] = v;
         end
         prev_idle = !m_req && !pend;
         prev_held = m_req && !m_gnt;
         if (cmpl) pend = 1'b0;
         else if (pend) p_age++;
         if (m_req && m_gnt) begin
            pend = 1'b1; p_age = 0; p_own_d = h_own_d; p_we = h_we;
            p_wstrb = h_wstrb; p_addr = h_addr; p_wdata = h_wdata;
         end
         prev_ireq = i_req; prev_iaddr = i_addr;
         prev_dreq = d_req; prev_dwe = d_we; prev_dwstrb = d_wstrb;
         prev_daddr = d_addr; prev_dwdata = d_wdata;
         next_cycle();
      end
   endtask

   initial begin
      idle_inputs();
      test_reset();
      test_min_latency();
      test_priority();
      test_gnt_delay_write();
`ifdef MEM_ARB_TIMEOUT_EN
      test_timeout();
`else
      test_no_timeout();
`endif
      test_reset_in_wait();
      test_random(3000);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
